apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_pkg.sv | 23 ++
 rtl/apb_timeout_cnt.sv | 29 ++
 rtl/apb_master_bridge.sv | 101 ++++++++++
 3 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the CPU-to-APB master bridge.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  localparam logic [31:0] DefBaseAddr = 32'h0000_7000;
  localparam logic [31:0] DefAddrMask = 32'hFFFF_F000;
  localparam int unsigned DefTimeout  = 255;
  localparam int unsigned WaitCntW    = 8;

  typedef logic [WaitCntW-1:0] wait_cnt_t;

  function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] mask,
                                          input logic [31:0] base);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; flags the stalled cycle that would reach TIMEOUT.
module apb_timeout_cnt
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam wait_cnt_t LastCnt = wait_cnt_t'(TIMEOUT - 1);

  wait_cnt_t cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + wait_cnt_t'(1);
    end
  end

  // Asserted during the stalled cycle whose increment makes the count equal TIMEOUT.
  assign expired = en && (cnt_q == LastCnt);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding CPU request to APB master bridge with address window and timeout.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefBaseAddr,
  parameter logic [31:0] ADDR_MASK = DefAddrMask,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic [31:0] PRDATA
);

  state_e state_q;
  logic   expired;

  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == StSetup),
    .en     ((state_q == StAccess) && !PREADY),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_rdy   <= 1'b1;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_vld) begin
            // The APB address/data registers double as the held request copy.
            PWRITE  <= req_we;
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            req_rdy <= 1'b0;
            if (addr_in_window(req_addr, ADDR_MASK, BASE_ADDR)) begin
              state_q <= StSetup;
              PSEL    <= 1'b1;
            end else begin
              state_q   <= StResp;
              rsp_vld   <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        StSetup: begin
          state_q <= StAccess;
          PENABLE <= 1'b1;
        end
        StAccess: begin
          if (PREADY || expired) begin
            state_q   <= StResp;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_err   <= PREADY ? PSLVERR : 1'b1;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
          end
        end
        StResp: begin
          if (rsp_rdy) begin
            state_q <= StIdle;
            rsp_vld <= 1'b0;
            req_rdy <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
